// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM dead-time guard.
//   - dead-time width / clamp defaults
//   - leg FSM state encoding (3-bit)
//   - clamp_dt(): saturate a requested dead time into [lo, hi]
package pwm_pkg;

  localparam int unsigned DT_W_DEF       = 8;
  localparam int unsigned MIN_DT_DEF     = 4;
  localparam int unsigned MAX_DT_DEF     = 200;
  localparam int unsigned DEFAULT_DT_DEF = 20;
  localparam int unsigned NUM_LEGS       = 2;

  localparam logic [2:0] LEG_OFF  = 3'd0;
  localparam logic [2:0] LEG_DT_H = 3'd1;
  localparam logic [2:0] LEG_HI   = 3'd2;
  localparam logic [2:0] LEG_DT_L = 3'd3;
  localparam logic [2:0] LEG_LO   = 3'd4;

  typedef enum logic [2:0] {
    S_OFF  = LEG_OFF,
    S_DT_H = LEG_DT_H,
    S_HI   = LEG_HI,
    S_DT_L = LEG_DT_L,
    S_LO   = LEG_LO
  } leg_state_e;

  function automatic int unsigned clamp_dt(input int unsigned v,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/deadtime_leg.sv
// deadtime_leg: one half-bridge leg. Turns a hi/lo request pair into gate
// drives with a dead time of dt_reg clocks before any gate turns on.
//   clock, reset_n : clock / async active-low reset
//   armed          : 0 forces the leg OFF with both gates low
//   dt_reg         : dead time in clocks (always >= MIN_DT)
//   hi, lo         : high-side / low-side request
//   gate_h, gate_l : registered gate drives, never both 1
module deadtime_leg
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            armed,
  input  logic [DT_W-1:0] dt_reg,
  input  logic            hi,
  input  logic            lo,
  output logic            gate_h,
  output logic            gate_l
);

  leg_state_e      state_q;
  logic [DT_W-1:0] cnt_q;
  logic            go_h, go_l;
  logic [DT_W-1:0] dt_m1;

  assign go_h  = hi & ~lo;
  assign go_l  = lo & ~hi;
  // dt_reg >= MIN_DT, so this never wraps
  assign dt_m1 = dt_reg - DT_W'(1);

  // Loading dt_reg-1 on the sampling edge and stepping to HI/LO on the edge
  // that sees cnt==0 puts the on-gate exactly dt_reg edges after sampling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      gate_h  <= 1'b0;
      gate_l  <= 1'b0;
    end else if (!armed) begin
      state_q <= S_OFF;
      gate_h  <= 1'b0;
      gate_l  <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (go_h) begin
            state_q <= S_DT_H;
            cnt_q   <= dt_m1;
          end else if (go_l) begin
            state_q <= S_DT_L;
            cnt_q   <= dt_m1;
          end
        end
        S_DT_H: begin
          if (go_h) begin
            if (cnt_q == '0) begin
              state_q <= S_HI;
              gate_h  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - DT_W'(1);
            end
          end else if (go_l) begin
            state_q <= S_DT_L;
            cnt_q   <= dt_m1;
          end else begin
            state_q <= S_OFF;
          end
        end
        S_DT_L: begin
          if (go_l) begin
            if (cnt_q == '0) begin
              state_q <= S_LO;
              gate_l  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - DT_W'(1);
            end
          end else if (go_h) begin
            state_q <= S_DT_H;
            cnt_q   <= dt_m1;
          end else begin
            state_q <= S_OFF;
          end
        end
        S_HI: begin
          // gate drops on the same edge the request goes away
          if (!hi) begin
            gate_h <= 1'b0;
            if (lo) begin
              state_q <= S_DT_L;
              cnt_q   <= dt_m1;
            end else begin
              state_q <= S_OFF;
            end
          end
        end
        S_LO: begin
          if (!lo) begin
            gate_l <= 1'b0;
            if (hi) begin
              state_q <= S_DT_H;
              cnt_q   <= dt_m1;
            end else begin
              state_q <= S_OFF;
            end
          end
        end
        default: begin
          state_q <= S_OFF;
          gate_h  <= 1'b0;
          gate_l  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime_guard.sv
// pwm_deadtime_guard: dead-time insertion and shoot-through guard between the
// PWM generator and the H-bridge gate pins.
//   clock, reset_n          : 200 MHz clock / async active-low reset
//   pwm_hi_1/lo_1           : leg A requests
//   pwm_hi_2/lo_2           : leg B requests
//   eop                     : end-of-period pulse (multi-cycle, edge detected)
//   enable                  : level request to drive the bridge
//   dead_cycles             : requested dead time, latched on period start
//   fault_clear             : clears the latched fault while enable=0
//   gate_ah/al/bh/bl        : registered gate drives
//   armed                   : bridge switching
//   fault                   : shoot-through request latched
module pwm_deadtime_guard
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W       = DT_W_DEF,
  parameter int unsigned MIN_DT     = MIN_DT_DEF,
  parameter int unsigned MAX_DT     = MAX_DT_DEF,
  parameter int unsigned DEFAULT_DT = DEFAULT_DT_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pwm_hi_1,
  input  logic            pwm_lo_1,
  input  logic            pwm_hi_2,
  input  logic            pwm_lo_2,
  input  logic            eop,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_cycles,
  input  logic            fault_clear,
  output logic            gate_ah,
  output logic            gate_al,
  output logic            gate_bh,
  output logic            gate_bl,
  output logic            armed,
  output logic            fault
);

  logic                eop_q;
  logic                armed_q, armed_d;
  logic                fault_q, fault_d;
  logic [DT_W-1:0]     dt_reg_q, dt_reg_d;
  logic                eop_rise, shoot, leg_run;
  logic [NUM_LEGS-1:0] req_hi, req_lo, gate_h, gate_l;

  assign req_hi   = {pwm_hi_2, pwm_hi_1};
  assign req_lo   = {pwm_lo_2, pwm_lo_1};
  assign eop_rise = eop & ~eop_q;
  assign shoot    = armed_q & (|(req_hi & req_lo));
  // Legs see the shoot-through on the edge it happens so gates drop together
  // with armed rather than one clock later.
  assign leg_run  = armed_q & ~shoot;

  always_comb begin
    dt_reg_d = dt_reg_q;
    if (eop_rise)
      dt_reg_d = DT_W'(clamp_dt(32'(dead_cycles), MIN_DT, MAX_DT));
  end

  // Priority: shoot-through > disable > arm on period boundary.
  always_comb begin
    armed_d = armed_q;
    if (shoot)                       armed_d = 1'b0;
    else if (!enable)                armed_d = 1'b0;
    else if (eop_rise && !fault_q)   armed_d = 1'b1;
  end

  always_comb begin
    fault_d = fault_q;
    if (shoot)                        fault_d = 1'b1;
    else if (fault_clear && !enable)  fault_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eop_q    <= 1'b0;
      armed_q  <= 1'b0;
      fault_q  <= 1'b0;
      dt_reg_q <= DT_W'(DEFAULT_DT);
    end else begin
      eop_q    <= eop;
      armed_q  <= armed_d;
      fault_q  <= fault_d;
      dt_reg_q <= dt_reg_d;
    end
  end

  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
    deadtime_leg #(.DT_W(DT_W)) u_leg (
      .clock   (clock),
      .reset_n (reset_n),
      .armed   (leg_run),
      .dt_reg  (dt_reg_q),
      .hi      (req_hi[g]),
      .lo      (req_lo[g]),
      .gate_h  (gate_h[g]),
      .gate_l  (gate_l[g])
    );
  end

  assign gate_ah = gate_h[0];
  assign gate_al = gate_l[0];
  assign gate_bh = gate_h[1];
  assign gate_bl = gate_l[1];
  assign armed   = armed_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_guard.sv
`timescale 1ns/100ps
module tb_pwm_deadtime_guard;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pwm_hi_1, pwm_lo_1, pwm_hi_2, pwm_lo_2;
  logic       eop, enable, fault_clear;
  logic [7:0] dead_cycles;
  logic       gate_ah, gate_al, gate_bh, gate_bl, armed, fault;

  int checks = 0;
  int errors = 0;

  pwm_deadtime_guard dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pwm_hi_1    (pwm_hi_1),
    .pwm_lo_1    (pwm_lo_1),
    .pwm_hi_2    (pwm_hi_2),
    .pwm_lo_2    (pwm_lo_2),
    .eop         (eop),
    .enable      (enable),
    .dead_cycles (dead_cycles),
    .fault_clear (fault_clear),
    .gate_ah     (gate_ah),
    .gate_al     (gate_al),
    .gate_bh     (gate_bh),
    .gate_bl     (gate_bl),
    .armed       (armed),
    .fault       (fault)
  );

  always #2.5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkdt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Switch leg A to hi (to_hi=1) or lo and expect the on-gate exactly d edges
  // after the sampling edge, the other gate low throughout.
  task automatic meas_a(input string tag, input int d, input logic to_hi);
    pwm_hi_1 = to_hi;
    pwm_lo_1 = ~to_hi;
    for (int k = 1; k <= d + 1; k++) begin
      tick(1);
      chk1(tag, to_hi ? gate_ah : gate_al, k == d + 1);
      chk1({tag, "_off"}, to_hi ? gate_al : gate_ah, 1'b0);
    end
  endtask

  task automatic eop_pulse();
    eop = 1'b1;
    tick(5);
    eop = 1'b0;
    tick(1);
  endtask

  // No leg may ever drive both gates.
  always @(negedge clock) begin
    checks++;
    assert (((gate_ah & gate_al) | (gate_bh & gate_bl)) === 1'b0) else begin
      errors++;
      $error("FAIL overlap: ah=%b al=%b bh=%b bl=%b expected no pair high",
             gate_ah, gate_al, gate_bh, gate_bl);
    end
  end

  initial begin
    reset_n = 1'b0;
    pwm_hi_1 = 1'b0; pwm_lo_1 = 1'b0; pwm_hi_2 = 1'b0; pwm_lo_2 = 1'b0;
    eop = 1'b0; enable = 1'b1; fault_clear = 1'b0; dead_cycles = 8'd10;
    tick(2);
    chk1("rst_ah", gate_ah, 1'b0);
    chk1("rst_al", gate_al, 1'b0);
    chk1("rst_bh", gate_bh, 1'b0);
    chk1("rst_bl", gate_bl, 1'b0);
    chk1("rst_armed", armed, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chkdt("rst_dt", dut.dt_reg_q, 8'd20);
    reset_n = 1'b1;
    tick(2);
    chk1("pre_eop_armed", armed, 1'b0);

    // 1: arm on first eop rise, hi request -> gate after 10 clocks
    eop = 1'b1;
    tick(1);
    chk1("t1_armed", armed, 1'b1);
    chkdt("t1_dt", dut.dt_reg_q, 8'd10);
    tick(4);
    eop = 1'b0;
    tick(1);
    pwm_hi_1 = 1'b1;
    pwm_hi_2 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk1("t1_ah", gate_ah, k == 11);
      chk1("t1_al", gate_al, 1'b0);
      chk1("t1_bh", gate_bh, k == 11);
    end

    // 2: both legs hi -> lo
    pwm_hi_1 = 1'b0; pwm_lo_1 = 1'b1;
    pwm_hi_2 = 1'b0; pwm_lo_2 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk1("t2_ah", gate_ah, 1'b0);
      chk1("t2_al", gate_al, k == 11);
      chk1("t2_bh", gate_bh, 1'b0);
      chk1("t2_bl", gate_bl, k == 11);
    end

    // 3: clamps and period-boundary latching of dead_cycles
    dead_cycles = 8'd0;
    eop_pulse();
    chkdt("t3_dt_min", dut.dt_reg_q, 8'd4);
    meas_a("t3_dt4_hi", 4, 1'b1);
    dead_cycles = 8'd255;
    tick(3);
    chkdt("t3_mid_dt", dut.dt_reg_q, 8'd4);
    meas_a("t3_mid_lo", 4, 1'b0);
    eop_pulse();
    chkdt("t3_dt_max", dut.dt_reg_q, 8'd200);
    meas_a("t3_dt200_hi", 200, 1'b1);
    dead_cycles = 8'd10;
    eop_pulse();
    chkdt("t3_dt10", dut.dt_reg_q, 8'd10);

    // 4: shoot-through on leg A (A in HI, B in LO)
    pwm_lo_1 = 1'b1;
    tick(1);
    pwm_lo_1 = 1'b0;
    chk1("t4_fault", fault, 1'b1);
    chk1("t4_armed", armed, 1'b0);
    chk1("t4_ah", gate_ah, 1'b0);
    chk1("t4_al", gate_al, 1'b0);
    chk1("t4_bh", gate_bh, 1'b0);
    chk1("t4_bl", gate_bl, 1'b0);
    pwm_hi_1 = 1'b0;
    pwm_lo_2 = 1'b0;
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk1("t4_clr_ignored", fault, 1'b1);
    enable = 1'b0;
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk1("t4_cleared", fault, 1'b0);
    chk1("t4_cleared_armed", armed, 1'b0);
    enable = 1'b1;
    tick(2);
    chk1("t4_no_midperiod_arm", armed, 1'b0);
    eop = 1'b1;
    tick(1);
    chk1("t4_rearm", armed, 1'b1);
    tick(4);
    eop = 1'b0;
    tick(1);

    // 5: glitch filter, then disable racing eop
    pwm_hi_1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (k == 3) pwm_hi_1 = 1'b0;
      chk1("t5_glitch_ah", gate_ah, 1'b0);
    end
    enable = 1'b0;
    eop = 1'b1;
    tick(1);
    chk1("t5_disable_wins", armed, 1'b0);
    tick(4);
    eop = 1'b0;
    tick(1);
    chk1("t5_still_disarmed", armed, 1'b0);

    // 6: asynchronous reset while HI
    enable = 1'b1;
    eop_pulse();
    chk1("t6_armed", armed, 1'b1);
    pwm_hi_1 = 1'b1;
    tick(11);
    chk1("t6_hi", gate_ah, 1'b1);
    #0.5;
    reset_n = 1'b0;
    #0.5;
    chk1("t6_async_ah", gate_ah, 1'b0);
    chk1("t6_async_armed", armed, 1'b0);
    tick(2);
    reset_n = 1'b1;
    pwm_hi_1 = 1'b0;
    tick(1);
    chkdt("t6_dt_default", dut.dt_reg_q, 8'd20);
    chk1("t6_post_ah", gate_ah, 1'b0);
    chk1("t6_post_armed", armed, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
